change_dispenser: RTL and testbench

//   Payout end of the vending machine's refund path: accepts a refund amount from the

---
 rtl/change_dispenser.sv | 164 ++++++++++++++++
 tb/tb_change_dispenser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: takes a refund amount and hands coins (10, 5, 1) to the hopper one at a time.
// Optional per-denomination tube inventory is enabled with `define COIN_INVENTORY_EN.
module change_dispenser #(
    parameter int AMT_W        = 6,
    parameter int DISPENSE_GAP = 1,
    parameter int TUBE_DEPTH   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund,
    output logic             refund_ready,
    output logic             coin_valid,
    output logic [AMT_W-1:0] coin_val,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    input  logic             restock,
    output logic             short
);

    typedef enum logic [2:0] {IDLE, LOAD, EMIT, GAP, DONE} state_t;

    localparam int GAP_W = (DISPENSE_GAP > 1) ? $clog2(DISPENSE_GAP) : 1;
    localparam logic [AMT_W-1:0] C10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] C5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] C1  = AMT_W'(1);

    state_t             state_reg, state_next;
    logic [AMT_W-1:0]   remaining_reg, remaining_next;
    logic [AMT_W-1:0]   coin_val_reg, coin_val_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               short_reg, short_next;
    logic [AMT_W-1:0]   rem_after_ack, coin_now, coin_post;
    // Tube availability, bit 2 = 10, bit 1 = 5, bit 0 = 1; "post" reflects the ack in flight.
    logic [2:0]         avail_now, avail_post;

    // Returns zero when no usable denomination fits the amount.
    function automatic logic [AMT_W-1:0] pick(input logic [AMT_W-1:0] amt, input logic [2:0] avail);
        logic [AMT_W-1:0] c;
        c = '0;
        if (amt >= C10 && avail[2])
            c = C10;
        else if (amt >= C5 && avail[1])
            c = C5;
        else if (amt != '0 && avail[0])
            c = C1;
        return c;
    endfunction

`ifdef COIN_INVENTORY_EN
    localparam int TUBE_W = $clog2(TUBE_DEPTH + 1);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tube
            localparam logic [AMT_W-1:0] DENOM = (gi == 2) ? C10 : (gi == 1) ? C5 : C1;
            logic [TUBE_W-1:0] tube_reg;
            logic              take;

            assign take           = (state_reg == EMIT) && coin_ack && (coin_val_reg == DENOM);
            assign avail_now[gi]  = (tube_reg != '0);
            assign avail_post[gi] = take ? (tube_reg > TUBE_W'(1)) : (tube_reg != '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    tube_reg <= TUBE_DEPTH[TUBE_W-1:0];
                else if (state_reg == IDLE && restock)
                    tube_reg <= TUBE_DEPTH[TUBE_W-1:0];
                else if (take)
                    tube_reg <= tube_reg - TUBE_W'(1);
            end
        end
    endgenerate
`else
    logic restock_unused;
    assign restock_unused = restock;
    assign avail_now      = 3'b111;
    assign avail_post     = 3'b111;
`endif

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        coin_val_next  = coin_val_reg;
        gap_next       = gap_reg;
        short_next     = short_reg;
        rem_after_ack  = remaining_reg - coin_val_reg;
        coin_now       = pick(remaining_reg, avail_now);
        coin_post      = pick(rem_after_ack, avail_post);
        case (state_reg)
            IDLE: begin
                if (refund_valid) begin
                    remaining_next = refund;
                    short_next     = 1'b0;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                if (remaining_reg == '0) begin
                    state_next = DONE;
                end else if (coin_now == '0) begin
                    short_next = 1'b1;
                    state_next = DONE;
                end else begin
                    coin_val_next = coin_now;
                    state_next    = EMIT;
                end
            end
            EMIT: begin
                if (coin_ack) begin
                    remaining_next = rem_after_ack;
                    if (rem_after_ack == '0) begin
                        state_next = DONE;
                    end else if (coin_post == '0) begin
                        short_next = 1'b1;
                        state_next = DONE;
                    end else if (DISPENSE_GAP > 0) begin
                        gap_next   = '0;
                        state_next = GAP;
                    end else begin
                        coin_val_next = coin_post;
                        state_next    = EMIT;
                    end
                end
            end
            GAP: begin
                if (gap_reg == GAP_W'(DISPENSE_GAP - 1)) begin
                    coin_val_next = coin_now;
                    state_next    = EMIT;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            coin_val_reg  <= '0;
            gap_reg       <= '0;
            short_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            coin_val_reg  <= coin_val_next;
            gap_reg       <= gap_next;
            short_reg     <= short_next;
        end
    end

    assign refund_ready = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign coin_valid   = (state_reg == EMIT);
    assign done         = (state_reg == DONE);
    assign coin_val     = coin_val_reg;
    assign remaining    = remaining_reg;
    assign short        = short_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and random refunds checked against a greedy payout model.
// Inventory scenarios are compiled in when COIN_INVENTORY_EN is defined.
module tb_change_dispenser;

    localparam int AMT_W      = 6;
    localparam int GAP        = 1;
    localparam int TUBE_DEPTH = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             refund_valid;
    logic [AMT_W-1:0] refund;
    logic             refund_ready;
    logic             coin_valid;
    logic [AMT_W-1:0] coin_val;
    logic             coin_ack;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] remaining;
    logic             restock;
    logic             short;

    int errors = 0;
    int checks = 0;

    int tubes [3];
    int exp_coins [$];
    int exp_left;
    int exp_short;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .DISPENSE_GAP(GAP),
        .TUBE_DEPTH  (TUBE_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refund_valid(refund_valid),
        .refund      (refund),
        .refund_ready(refund_ready),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .coin_ack    (coin_ack),
        .busy        (busy),
        .done        (done),
        .remaining   (remaining),
        .restock     (restock),
        .short       (short)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic refill_model();
`ifdef COIN_INVENTORY_EN
        foreach (tubes[i]) tubes[i] = TUBE_DEPTH;
`else
        foreach (tubes[i]) tubes[i] = 32'h7fff_ffff;
`endif
    endtask

    // Greedy payout over the denominations that still have coins in the model's tubes.
    task automatic model(input int amt);
        int a;
        int c;
        a = amt;
        exp_coins.delete();
        exp_short = 0;
        while (a > 0) begin
            c = 0;
            if (a >= 10 && tubes[2] > 0) c = 10;
            else if (a >= 5 && tubes[1] > 0) c = 5;
            else if (tubes[0] > 0) c = 1;
            if (c == 0) begin
                exp_short = 1;
                break;
            end
            exp_coins.push_back(c);
            a -= c;
            if (c == 10) tubes[2]--;
            else if (c == 5) tubes[1]--;
            else tubes[0]--;
        end
        exp_left = a;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".refund_ready"}, 32'(refund_ready), 1);
        check({tag, ".coin_valid"}, 32'(coin_valid), 0);
        check({tag, ".coin_val"}, 32'(coin_val), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".remaining"}, 32'(remaining), 0);
        check({tag, ".short"}, 32'(short), 0);
    endtask

    task automatic noise();
        coin_ack     = 1'($urandom_range(0, 1));
        refund_valid = 1'($urandom_range(0, 1));
        refund       = AMT_W'($urandom);
    endtask

    // delay < 0 picks a random ack latency for every coin.
    task automatic payout(input int amt, input int delay);
        int rem;
        int d;
        model(amt);
        refund_valid = 1'b1;
        refund       = AMT_W'(amt);
        tick();
        refund_valid = 1'b0;
        check("load.coin_valid", 32'(coin_valid), 0);
        check("load.busy", 32'(busy), 1);
        check("load.refund_ready", 32'(refund_ready), 0);
        check("load.remaining", 32'(remaining), amt);
        noise();
        tick();
        rem = amt;
        foreach (exp_coins[i]) begin
            d = (delay < 0) ? $urandom_range(0, 3) : delay;
            for (int k = 0; k <= d; k++) begin
                check("emit.coin_valid", 32'(coin_valid), 1);
                check("emit.coin_val", 32'(coin_val), exp_coins[i]);
                check("emit.remaining", 32'(remaining), rem);
                check("emit.refund_ready", 32'(refund_ready), 0);
                coin_ack     = (k == d);
                refund_valid = 1'($urandom_range(0, 1));
                refund       = AMT_W'(8);
                tick();
            end
            coin_ack     = 1'b0;
            refund_valid = 1'b0;
            rem -= exp_coins[i];
            if (i < exp_coins.size() - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    check("gap.coin_valid", 32'(coin_valid), 0);
                    check("gap.busy", 32'(busy), 1);
                    noise();
                    tick();
                end
            end
        end
        coin_ack     = 1'b0;
        refund_valid = 1'b0;
        check("done.done", 32'(done), 1);
        check("done.coin_valid", 32'(coin_valid), 0);
        check("done.remaining", 32'(remaining), exp_left);
        check("done.short", 32'(short), exp_short);
        tick();
        check("idle.done", 32'(done), 0);
        check("idle.refund_ready", 32'(refund_ready), 1);
        check("idle.busy", 32'(busy), 0);
        check("idle.remaining", 32'(remaining), exp_left);
        $display("payout refund=%0d coins=%0d left=%0d short=%0d", amt, exp_coins.size(), exp_left, exp_short);
    endtask

    initial begin
        reset        = 1'b1;
        refund_valid = 1'b0;
        refund       = '0;
        coin_ack     = 1'b0;
        restock      = 1'b0;
        refill_model();
        #3;
        check_reset_values("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("post_reset");

        payout(27, 0);
        payout(0, -1);
        payout(15, 5);
        payout(1, -1);
        payout(63, -1);

        // Abort a payout of 27 after the first coin with an asynchronous reset.
        model(27);
        refund_valid = 1'b1;
        refund       = AMT_W'(27);
        tick();
        refund_valid = 1'b0;
        tick();
        check("abort.coin_val", 32'(coin_val), 10);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        #3;
        reset = 1'b0;
        refill_model();
        for (int i = 0; i < 4; i++) begin
            coin_ack = 1'($urandom_range(0, 1));
            tick();
            check("abort.no_coin", 32'(coin_valid), 0);
            check("abort.refund_ready", 32'(refund_ready), 1);
        end
        coin_ack = 1'b0;
        $display("payout refund=27 aborted by reset");

        for (int n = 0; n < 12; n++) begin
            payout($urandom_range(0, 63), -1);
        end

`ifdef COIN_INVENTORY_EN
        restock = 1'b1;
        tick();
        restock = 1'b0;
        refill_model();
        payout(7, -1);
        payout(23, -1);
        for (int n = 0; n < 6; n++) begin
            payout($urandom_range(20, 63), -1);
        end
        restock = 1'b1;
        tick();
        restock = 1'b0;
        refill_model();
        payout(7, 0);
        check("restock.short", 32'(short), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
